sha256d_iter_engine: RTL
========================

Name: sha256d_iter_engine

Overview:
- Sequential, area-lean SHA-256 / double-SHA-256 hasher that consumes pre-padded 512-bit message blocks and produces a 256-bit digest.
- Computes one compression round per clock.
- Sits in the sighash datapath as the iterative engine for the BIP143 hashes: prevouts hash, outputs hash, and the final sighash over the 4-block preimage.
- Upstream framing logic streams padded blocks in; the digest is handed downstream to the signature/commitment stage.

Parameters:
- DOUBLE, 1: 1 = apply a second SHA-256 over the 256-bit first digest (SHA256d); 0 = single SHA-256.
- H0, 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19: initial chaining value.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  in_block/in_last valid.
- in_ready  output  1  engine can accept a block this cycle.
- in_block  input  512  pre-padded message block, big-endian, word 0 in [511:480].
- in_last  input  1  block is the final block of the message.
- out_valid  output  1  out_digest valid.
- out_ready  input  1  downstream accepts digest.
- out_digest  output  256  final digest, big-endian, H0 word in [255:224].
- busy  output  1  high in any state except IDLE.

Behaviour:
- Reset (async, rst=1): state IDLE, chaining reg = H0, round counter = 0, out_valid = 0, out_digest = 0, in_ready = 1, busy = 0. Reset mid-operation abandons the message with no output.
- States:
  - IDLE: in_ready = 1.
  - ROUND1: 64 cycles, counter 0..63.
  - FEED1: 1 cycle.
  - WAIT_BLK: in_ready = 1, chaining value held.
  - ROUND2: 64 cycles.
  - FEED2: 1 cycle.
  - DONE: out_valid = 1.
- Accept = in_valid & in_ready. Latch in_block into a 16-word schedule window and in_last into last_q. Copy chaining into working vars a..h. Go to ROUND1.
- ROUND1: one round per cycle using K[cnt] and W[cnt]. The W window shifts, computing W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], all mod 2^32. At cnt = 63 go to FEED1.
- FEED1: chaining = chaining + {a..h} per 32-bit word, mod 2^32.
  - If !last_q: go to WAIT_BLK.
  - If last_q & DOUBLE: load the block {chaining_new, 256'h80000000_00000000_00000000_00000000_00000000_00000000_00000000_00000100}, reset the working vars and temporary chaining to H0, go to ROUND2.
  - If last_q & !DOUBLE: out_digest <= chaining_new, go to DONE.
- FEED2: out_digest <= H0 + {a..h}, go to DONE.
- Latency, accept edge of last block to out_valid high: 65 cycles (DOUBLE=0) or 130 cycles (DOUBLE=1). Inter-block accept spacing is at least 65 cycles.
- DONE: out_valid and out_digest hold stable until out_ready. On out_valid & out_ready: out_valid falls next cycle, chaining = H0, go to IDLE. in_ready = 0 in DONE; the next message can be accepted no earlier than the cycle after the handshake.
- in_ready is registered from state and is never high in ROUND*/FEED*/DONE. in_valid asserted in those states is ignored and not buffered.
- out_ready while out_valid = 0 has no effect.
- Message length and padding are upstream's responsibility. The engine does no length check.

Decomposition:
- sha256_pkg: K[0:63] constant array, H0, 256-bit second-pass pad constant, state enum, functions Ch, Maj, Sigma0/1, sigma0/1, and a 256-bit lane-wise add.
- One sub-module: sha256_round. Combinational single round taking a..h, Kt, Wt and returning the next a..h; instantiated once.
- Schedule window, counter, FSM and chaining registers live in the top module.

Test Plan:
- DOUBLE=0, single block "abc" (0x616263 80 00.. 0x18) -> out_digest = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, out_valid exactly 65 cycles after accept.
- DOUBLE=1, empty message (block 0x80 00..00) -> 5df6e0e2761359d30a8275058e299fcc0381534545f55cf43e41983f5d4c9456, out_valid 130 cycles after accept.
- DOUBLE=1, "abc" -> 4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358.
- DOUBLE=0, 2-block NIST vector "abcdbcdecdefdefg...nopq" (448 bits) with 20-cycle gap in WAIT_BLK -> 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
- Backpressure: hold out_ready = 0 for 50 cycles -> out_valid/out_digest stable, in_ready = 0, in_valid pulses ignored. Release -> IDLE next cycle, next "abc" hash correct.
- Assert rst at round 30 of the first block -> all outputs at reset values immediately, in_ready = 1. A subsequent empty-message hash is correct with no carry-over.

Source files
------------

// File: rtl/sha256_pkg.sv
// SHA-256 constants, state encoding and round/schedule helper functions
// shared by the iterative double-SHA-256 engine and its round datapath.
package sha256_pkg;

   localparam logic [255:0] SHA256_H0 =
      256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

   // Padding and length (256 bits) for hashing a 32-byte first-pass digest
   localparam logic [255:0] SHA256_PAD2 =
      256'h80000000_00000000_00000000_00000000_00000000_00000000_00000000_00000100;

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   typedef enum logic [2:0] {
      S_IDLE,
      S_ROUND1,
      S_FEED1,
      S_WAIT_BLK,
      S_ROUND2,
      S_FEED2,
      S_DONE
   } state_t;

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
      return (x & y) ^ (~x & z);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction

   function automatic logic [31:0] big_sigma0(input logic [31:0] x);
      return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
   endfunction

   function automatic logic [31:0] big_sigma1(input logic [31:0] x);
      return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
   endfunction

   function automatic logic [31:0] small_sigma0(input logic [31:0] x);
      return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] small_sigma1(input logic [31:0] x);
      return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
   endfunction

   // Eight independent 32-bit additions; carries never cross word lanes
   function automatic logic [255:0] add256(input logic [255:0] x, input logic [255:0] y);
      logic [255:0] sum;
      for (int i = 0; i < 8; i++) begin
         sum[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
      end
      return sum;
   endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round: {a..h} in, {a..h} out,
// with a in the top word of each 256-bit bundle.
module sha256_round
   import sha256_pkg::*;
(
   input  logic [255:0] vars,
   input  logic [31:0]  kt,
   input  logic [31:0]  wt,
   output logic [255:0] next_vars
);

   logic [31:0] a, b, c, d, e, f, g, h;
   logic [31:0] t1, t2;

   assign {a, b, c, d, e, f, g, h} = vars;

   assign t1 = h + big_sigma1(e) + ch(e, f, g) + kt + wt;
   assign t2 = big_sigma0(a) + maj(a, b, c);

   assign next_vars = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256d_iter_engine.sv
// Iterative SHA-256 / SHA-256d engine: one round per clock over pre-padded
// 512-bit blocks, optional second pass over the 256-bit first digest.
module sha256d_iter_engine
   import sha256_pkg::*;
#(
   parameter bit           DOUBLE = 1'b1,
   parameter logic [255:0] H0     = SHA256_H0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [511:0] in_block,
   input  logic         in_last,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [255:0] out_digest,
   output logic         busy
);

   state_t        state;
   state_t        state_next;
   logic [5:0]    cnt;
   logic [31:0]   w [16];
   logic [31:0]   w_new;
   logic [255:0]  work;
   logic [255:0]  chain;
   logic [255:0]  chain_sum;
   logic [255:0]  round_next;
   logic [511:0]  pass2_block;
   logic          last_q;
   logic          accept;

   assign accept      = in_valid & in_ready;
   assign busy        = (state != S_IDLE);
   assign chain_sum   = add256(chain, work);
   assign pass2_block = {chain_sum, SHA256_PAD2};

   // w[0] is W[t]; w_new is W[t+16], shifted in as the window advances
   assign w_new = small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];

   sha256_round u_round (
      .vars      (work),
      .kt        (K[cnt]),
      .wt        (w[0]),
      .next_vars (round_next)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE, S_WAIT_BLK: if (accept) state_next = S_ROUND1;
         S_ROUND1:           if (cnt == 6'd63) state_next = S_FEED1;
         S_FEED1: begin
            if (!last_q)     state_next = S_WAIT_BLK;
            else if (DOUBLE) state_next = S_ROUND2;
            else             state_next = S_DONE;
         end
         S_ROUND2:           if (cnt == 6'd63) state_next = S_FEED2;
         S_FEED2:            state_next = S_DONE;
         S_DONE:             if (out_ready) state_next = S_IDLE;
         default:            state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         out_digest <= '0;
         chain      <= H0;
         work       <= '0;
         cnt        <= '0;
         last_q     <= 1'b0;
         for (int i = 0; i < 16; i++) w[i] <= '0;
      end else begin
         // Handshake flags follow the state being entered, so they are glitch-free flops
         in_ready  <= (state_next == S_IDLE) || (state_next == S_WAIT_BLK);
         out_valid <= (state_next == S_DONE);
         case (state)
            S_IDLE, S_WAIT_BLK: begin
               if (accept) begin
                  for (int i = 0; i < 16; i++) w[i] <= in_block[511 - 32*i -: 32];
                  last_q <= in_last;
                  work   <= chain;
                  cnt    <= '0;
               end
            end
            S_ROUND1, S_ROUND2: begin
               work <= round_next;
               for (int i = 0; i < 15; i++) w[i] <= w[i+1];
               w[15] <= w_new;
               cnt   <= cnt + 6'd1;
            end
            S_FEED1: begin
               chain <= chain_sum;
               if (last_q) begin
                  if (DOUBLE) begin
                     for (int i = 0; i < 16; i++) w[i] <= pass2_block[511 - 32*i -: 32];
                     work  <= H0;
                     chain <= H0;
                  end else begin
                     out_digest <= chain_sum;
                  end
               end
            end
            S_FEED2: out_digest <= add256(H0, work);
            S_DONE:  if (out_ready) chain <= H0;
            default: ;
         endcase
      end
   end

endmodule
